// File: rtl/procyon_lsu_arb.sv
// procyon_lsu_arb: LSU issue arbiter (fill > retire > replay/new) with starvation boost and registered issue bundle
module procyon_lsu_arb #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_LQ_DEPTH      = 8,
  parameter int OPTN_SQ_DEPTH      = 8,
  parameter int OPTN_DC_LINE_SIZE  = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_STARVE_LIMIT  = 4,
  parameter int PCYN_OP_WIDTH      = 5,
  parameter int PCYN_OP_IS_WIDTH   = 2,
  parameter int PCYN_OP_IS_LD_IDX  = 0,
  parameter int PCYN_OP_IS_ST_IDX  = 1,
  parameter logic [PCYN_OP_WIDTH-1:0] PCYN_OP_FILL = 5'd15,
  localparam int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic                          i_fill_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_fill_addr,
  input  logic [DC_LINE_WIDTH-1:0]      i_fill_data,
  input  logic                          i_sq_retire_en,
  input  logic [PCYN_OP_WIDTH-1:0]      i_sq_retire_op,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_sq_retire_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_sq_retire_data,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_sq_retire_tag,
  input  logic [OPTN_SQ_DEPTH-1:0]      i_sq_retire_select,
  output logic                          o_sq_retire_stall,
  input  logic                          i_lq_replay_en,
  input  logic                          i_lq_replay_fill,
  input  logic [PCYN_OP_WIDTH-1:0]      i_lq_replay_op,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_lq_replay_addr,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_lq_replay_tag,
  input  logic [OPTN_LQ_DEPTH-1:0]      i_lq_replay_select,
  output logic                          o_lq_replay_stall,
  input  logic                          i_valid,
  input  logic [PCYN_OP_WIDTH-1:0]      i_op,
  input  logic [PCYN_OP_IS_WIDTH-1:0]   i_op_is,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_data,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag,
  input  logic [OPTN_LQ_DEPTH-1:0]      i_alloc_lq_select,
  input  logic [OPTN_SQ_DEPTH-1:0]      i_alloc_sq_select,
  output logic                          o_stall,
  output logic                          o_valid,
  output logic                          o_fill_replay,
  output logic                          o_retire,
  output logic [PCYN_OP_WIDTH-1:0]      o_op,
  output logic [PCYN_OP_IS_WIDTH-1:0]   o_op_is,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_addr,
  output logic [OPTN_DATA_WIDTH-1:0]    o_data,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_tag,
  output logic [DC_LINE_WIDTH-1:0]      o_fill_data,
  output logic [OPTN_LQ_DEPTH-1:0]      o_lq_select,
  output logic [OPTN_SQ_DEPTH-1:0]      o_sq_select
);
  localparam int SW = $clog2(OPTN_STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic new_req, rep_req, boost, g_fill, g_ret, g_rep, g_new;
  logic valid_d, fill_replay_d, retire_d;
  logic [PCYN_OP_WIDTH-1:0] op_d;
  logic [PCYN_OP_IS_WIDTH-1:0] op_is_d;
  logic [OPTN_ADDR_WIDTH-1:0] addr_d;
  logic [OPTN_DATA_WIDTH-1:0] data_d;
  logic [OPTN_ROB_IDX_WIDTH-1:0] tag_d;
  logic [DC_LINE_WIDTH-1:0] fill_data_d;
  logic [OPTN_LQ_DEPTH-1:0] lq_select_d;
  logic [OPTN_SQ_DEPTH-1:0] sq_select_d;
  // Grant selection: committed fill/retire always outrank speculative replay/new, which flush suppresses
  always_comb begin
    new_req           = i_valid && !i_flush;
    rep_req           = i_lq_replay_en && !i_flush;
    boost             = starve_q == SW'(OPTN_STARVE_LIMIT);
    g_fill            = i_fill_en;
    g_ret             = i_sq_retire_en && !i_fill_en;
    g_rep             = rep_req && !i_fill_en && !i_sq_retire_en && !(new_req && boost);
    g_new             = new_req && !i_fill_en && !i_sq_retire_en && !g_rep;
    o_sq_retire_stall = i_sq_retire_en && !g_ret;
    o_lq_replay_stall = rep_req && !g_rep;
    o_stall           = new_req && !g_new;
    starve_d          = (!i_valid || i_flush || g_new) ? '0 :
                        (o_stall && !boost) ? starve_q + 1'b1 : starve_q;
  end
  // Issue bundle mux: fields of whichever requester won, zero where that source has none
  always_comb begin
    valid_d       = g_fill || g_ret || g_rep || g_new;
    fill_replay_d = g_rep && i_lq_replay_fill;
    retire_d      = g_ret;
    op_d          = g_fill ? PCYN_OP_FILL : g_ret ? i_sq_retire_op : g_rep ? i_lq_replay_op : g_new ? i_op : '0;
    op_is_d       = g_new ? i_op_is : '0;
    addr_d        = g_fill ? i_fill_addr : g_ret ? i_sq_retire_addr : g_rep ? i_lq_replay_addr : g_new ? i_addr : '0;
    data_d        = g_ret ? i_sq_retire_data : g_new ? i_data : '0;
    tag_d         = g_ret ? i_sq_retire_tag : g_rep ? i_lq_replay_tag : g_new ? i_tag : '0;
    fill_data_d   = g_fill ? i_fill_data : '0;
    lq_select_d   = g_rep ? i_lq_replay_select : (g_new && i_op_is[PCYN_OP_IS_LD_IDX]) ? i_alloc_lq_select : '0;
    sq_select_d   = g_ret ? i_sq_retire_select : (g_new && i_op_is[PCYN_OP_IS_ST_IDX]) ? i_alloc_sq_select : '0;
  end
  // Register the issue bundle and starvation counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      starve_q      <= '0;
      o_valid       <= 1'b0;
      o_fill_replay <= 1'b0;
      o_retire      <= 1'b0;
      o_op          <= '0;
      o_op_is       <= '0;
      o_addr        <= '0;
      o_data        <= '0;
      o_tag         <= '0;
      o_fill_data   <= '0;
      o_lq_select   <= '0;
      o_sq_select   <= '0;
    end else begin
      starve_q      <= starve_d;
      o_valid       <= valid_d;
      o_fill_replay <= fill_replay_d;
      o_retire      <= retire_d;
      o_op          <= op_d;
      o_op_is       <= op_is_d;
      o_addr        <= addr_d;
      o_data        <= data_d;
      o_tag         <= tag_d;
      o_fill_data   <= fill_data_d;
      o_lq_select   <= lq_select_d;
      o_sq_select   <= sq_select_d;
    end
  end
endmodule
